// File: rtl/tlb_op_ctrl_if.sv
// Op request / response channel between the EXE-side issuer and tlb_op_ctrl.
// master = issuer (EXE/CSR/WB side), slave = tlb_op_ctrl.
interface tlb_op_ctrl_if #(
  parameter int unsigned TLBNUM = 16
);
  localparam int unsigned IDXW = $clog2(TLBNUM);

  logic            op_valid;
  logic            op_ready;
  logic [2:0]      op_code;
  logic [4:0]      op_inv_code;
  logic [9:0]      op_asid;
  logic [18:0]     op_vppn;
  logic            resp_valid;
  logic            resp_ready;
  logic [2:0]      resp_op;
  logic            resp_found;
  logic [IDXW-1:0] resp_index;

  modport master (
    output op_valid, op_code, op_inv_code, op_asid, op_vppn, resp_ready,
    input  op_ready, resp_valid, resp_op, resp_found, resp_index
  );

  modport slave (
    input  op_valid, op_code, op_inv_code, op_asid, op_vppn, resp_ready,
    output op_ready, resp_valid, resp_op, resp_found, resp_index
  );
endinterface

// File: rtl/tlb_op_ctrl.sv
// Sequences TLB maintenance ops onto the TLB and arbitrates search port 1 with load/store.
// Optional TLB_FILL_LFSR_EN: TLBFILL index comes from a 16-bit LFSR instead of a wrap counter.
module tlb_op_ctrl #(
  parameter int unsigned TLBNUM   = 16,
  parameter int unsigned WAIT_MAX = 4,
  localparam int unsigned IDXW    = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            resetn,
  tlb_op_ctrl_if.slave    op_bus,
  input  logic [IDXW-1:0] csr_tlbidx_index,
  input  logic            csr_tlbidx_ne,
  input  logic            ls_req_valid,
  input  logic [18:0]     ls_vppn,
  input  logic            ls_va_bit12,
  input  logic [9:0]      ls_asid,
  output logic            ls_grant,
  output logic [18:0]     s1_vppn,
  output logic            s1_va_bit12,
  output logic [9:0]      s1_asid,
  input  logic            s1_found,
  input  logic [IDXW-1:0] s1_index,
  output logic [IDXW-1:0] tlb_r_index,
  output logic            tlb_we,
  output logic [IDXW-1:0] tlb_w_index,
  output logic            tlb_w_e,
  output logic            invtlb_valid,
  output logic [4:0]      invtlb_op
);

  localparam logic [2:0] OpSrch = 3'd0;
  localparam logic [2:0] OpRd   = 3'd1;
  localparam logic [2:0] OpWr   = 3'd2;
  localparam logic [2:0] OpFill = 3'd3;
  localparam logic [2:0] OpInv  = 3'd4;

  localparam int unsigned WaitW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic [WaitW-1:0] WaitMax = WaitW'(WAIT_MAX);

  typedef enum logic [1:0] {StIdle, StArb, StExec, StResp} state_e;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [2:0]       op_code_q;
  logic [4:0]       op_inv_code_q;
  logic [9:0]       op_asid_q;
  logic [18:0]      op_vppn_q;
  logic             resp_found_q;
  logic [IDXW-1:0]  resp_index_q;
  logic [IDXW-1:0]  fill_idx;

  logic accept;
  logic in_is_port_op;
  logic is_port_op;
  logic in_exec;

  assign accept        = (state_q == StIdle) && op_bus.op_valid;
  assign in_is_port_op = (op_bus.op_code == OpSrch) || (op_bus.op_code == OpInv);
  assign is_port_op    = (op_code_q == OpSrch) || (op_code_q == OpInv);
  assign in_exec       = (state_q == StExec);

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      StIdle: begin
        if (op_bus.op_valid) begin
          if (in_is_port_op) begin
            state_d = StArb;
            wait_d  = '0;
          end else begin
            state_d = StExec;
          end
        end
      end
      StArb: begin
        if (!ls_req_valid || (wait_q == WaitMax)) begin
          state_d = StExec;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StExec: state_d = StResp;
      StResp: if (op_bus.resp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_code_q     <= '0;
      op_inv_code_q <= '0;
      op_asid_q     <= '0;
      op_vppn_q     <= '0;
    end else if (accept) begin
      op_code_q     <= op_bus.op_code;
      op_inv_code_q <= op_bus.op_inv_code;
      op_asid_q     <= op_bus.op_asid;
      op_vppn_q     <= op_bus.op_vppn;
    end
  end

  // Search result is captured in EXEC; non-search ops report zeros.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      resp_found_q <= 1'b0;
      resp_index_q <= '0;
    end else if (in_exec) begin
      resp_found_q <= (op_code_q == OpSrch) && s1_found;
      resp_index_q <= (op_code_q == OpSrch) ? s1_index : '0;
    end
  end

`ifdef TLB_FILL_LFSR_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign fill_idx = lfsr_q[IDXW-1:0];
`else
  logic [IDXW-1:0] fill_cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fill_cnt_q <= '0;
    end else if (fill_cnt_q == IDXW'(TLBNUM - 1)) begin
      fill_cnt_q <= '0;
    end else begin
      fill_cnt_q <= fill_cnt_q + IDXW'(1);
    end
  end

  assign fill_idx = fill_cnt_q;
`endif

  // Port 1 belongs to load/store except during the one EXEC cycle of SRCH/INV.
  always_comb begin
    ls_grant    = ls_req_valid;
    s1_vppn     = ls_vppn;
    s1_va_bit12 = ls_va_bit12;
    s1_asid     = ls_asid;
    if (in_exec && is_port_op) begin
      ls_grant    = 1'b0;
      s1_vppn     = op_vppn_q;
      s1_va_bit12 = 1'b0;
      s1_asid     = op_asid_q;
    end
  end

  always_comb begin
    tlb_we      = 1'b0;
    tlb_w_index = csr_tlbidx_index;
    if (in_exec && (op_code_q == OpWr)) begin
      tlb_we = 1'b1;
    end else if (in_exec && (op_code_q == OpFill)) begin
      tlb_we      = 1'b1;
      tlb_w_index = fill_idx;
    end
  end

  assign tlb_w_e      = ~csr_tlbidx_ne;
  assign tlb_r_index  = csr_tlbidx_index;
  assign invtlb_valid = in_exec && (op_code_q == OpInv);
  assign invtlb_op    = op_inv_code_q;

  assign op_bus.op_ready   = (state_q == StIdle);
  assign op_bus.resp_valid = (state_q == StResp);
  assign op_bus.resp_op    = op_code_q;
  assign op_bus.resp_found = resp_found_q;
  assign op_bus.resp_index = resp_index_q;

endmodule

// File: doc/tlb_op_ctrl.md
Name: tlb_op_ctrl

Overview:
Sequences TLB maintenance instructions (TLBSRCH, TLBRD, TLBWR, TLBFILL, INVTLB) from the EXE stage onto the 16-entry TLB.
Shares TLB search port 1 between the load/store MMU lookup and the TLBSRCH/INVTLB ops, using bounded-wait arbitration.
Generates the TLBFILL replacement index and returns results to the CSR/WB side through a valid/ready response.
One op is in flight at a time.

Parameters:
TLBNUM, 16, number of TLB entries; IDXW = $clog2(TLBNUM)
WAIT_MAX, 4, max cycles an op waits in ARB while load/store holds port 1; 0 = immediate preemption

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
op_valid  in  1  op request
op_ready  out  1  high only in IDLE
op_code  in  3  0 SRCH, 1 RD, 2 WR, 3 FILL, 4 INV; 5-7 = no-op
op_inv_code  in  5  INVTLB op field
op_asid  in  10  ASID for SRCH/INV
op_vppn  in  19  VPPN for SRCH/INV
csr_tlbidx_index  in  IDXW  TLBIDX.index for RD/WR
csr_tlbidx_ne  in  1  TLBIDX.NE
ls_req_valid  in  1  load/store lookup request
ls_vppn  in  19  load/store VPPN
ls_va_bit12  in  1  load/store VA[12]
ls_asid  in  10  load/store ASID
ls_grant  out  1  port 1 carries the load/store lookup this cycle
s1_vppn  out  19  TLB search port 1 VPPN
s1_va_bit12  out  1  TLB search port 1 VA[12]
s1_asid  out  10  TLB search port 1 ASID
s1_found  in  1  TLB search result
s1_index  in  IDXW  TLB search result index
tlb_r_index  out  IDXW  TLB read index
tlb_we  out  1  TLB write enable
tlb_w_index  out  IDXW  TLB write index
tlb_w_e  out  1  TLB write E bit
invtlb_valid  out  1  INVTLB strobe
invtlb_op  out  5  INVTLB opcode
resp_valid  out  1  response valid
resp_ready  in  1  response accept
resp_op  out  3  op_code of the completed op
resp_found  out  1  SRCH hit
resp_index  out  IDXW  SRCH hit index

Behaviour:
- States: IDLE, ARB, EXEC, RESP. Encoding is free.
- On reset:
  - state = IDLE; all registers are 0; fill counter = 0.
  - Outputs: op_ready=1, resp_valid=0, tlb_we=0, invtlb_valid=0, ls_grant=ls_req_valid.
- IDLE:
  - An op is accepted on op_valid && op_ready; op fields are latched.
  - SRCH or INV -> ARB, with wait_cnt cleared.
  - RD, WR, FILL, or a no-op code -> EXEC.
- ARB:
  - If !ls_req_valid or wait_cnt==WAIT_MAX -> EXEC.
  - Otherwise wait_cnt increments (saturating).
  - Load/store remains granted throughout ARB.
- EXEC lasts one cycle and ls_grant=0.
  - SRCH: port 1 is driven with the latched op_vppn, op_asid and va_bit12=0. s1_found and s1_index are registered into resp_found and resp_index at the clock edge.
  - INV: port 1 is driven with the latched asid/vppn; invtlb_valid=1; invtlb_op = latched op_inv_code.
  - RD: tlb_r_index = csr_tlbidx_index. The CSR block samples the r_* fields this cycle.
  - WR: tlb_we=1; tlb_w_index = csr_tlbidx_index; tlb_w_e = ~csr_tlbidx_ne.
  - FILL: tlb_we=1; tlb_w_index = current fill index; tlb_w_e = ~csr_tlbidx_ne.
  - No-op: no TLB side effects.
  - EXEC -> RESP.
- RESP:
  - resp_valid=1; resp_op, resp_found and resp_index are held stable.
  - On resp_ready -> IDLE; the next op can be accepted in the following cycle.
  - resp_found and resp_index are 0 for every op other than SRCH.
- Port 1 mux: outside SRCH/INV EXEC, s1_* = ls_* and ls_grant = ls_req_valid. During SRCH/INV EXEC, ls_grant=0.
- tlb_r_index holds csr_tlbidx_index in every state.
- Latency from accept to resp_valid:
  - RD/WR/FILL: 2 cycles.
  - SRCH/INV: 3 cycles with no contention; at most 3+WAIT_MAX cycles.
- Fill counter: IDXW bits; increments every cycle after reset; wraps TLBNUM-1 -> 0.
- Reset asserted mid-op: the op is discarded without a response; no TLB write occurs after reset is asserted.
- op_valid outside IDLE is ignored.

Optional Feature:
TLB_FILL_LFSR_EN:
- Defined: the fill index is lfsr[IDXW-1:0].
  - lfsr is a 16-bit Fibonacci LFSR, taps 16,14,13,11; reset seed 16'hACE1; shifts every cycle.
- Undefined: the fill index is the wrap-around counter.

Test Plan:
- SRCH, no ls traffic: accept at cycle 0, vppn=19'h00123, asid=10'h5, TLB hits entry 7. Required: EXEC at cycle 2 with ls_grant=0; resp_valid at cycle 3 with found=1, index=7.
- SRCH with ls_req_valid held high, WAIT_MAX=4. Required: EXEC delayed exactly 4 cycles; ls_grant low for exactly one cycle; no ls lookup lost besides that cycle.
- WR with csr_tlbidx_index=3 and ne=1. Required: single-cycle tlb_we=1, w_index=3, w_e=0; resp at accept+2.
- FILL with LFSR off, timed so that EXEC sees counter=5. Required: w_index=5. A repeated FILL at counter 15 followed by a later one at counter 0 gives indices 15 then 0.
- INV op 5, asid=10'h2, vppn=19'h1F000. Required: one-cycle invtlb_valid, invtlb_op=5, s1_asid=2, s1_vppn=19'h1F000 in that cycle.
- Reset during ARB of a SRCH, then resp_ready held low after a later RD:
  - After reset: state IDLE, no response, tlb_we never asserted.
  - During the RD response: resp_valid stays 1 and fields stay stable until resp_ready rises.
